// File: rtl/i2cm_byte_tx_pkg.sv
// Shared types and bus waveforms for the i2cm byte transmitter.
// Pure declarations: no latency, no backpressure.
package i2cm_byte_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int ACK_CNT_W = 8;
  localparam logic [ACK_CNT_W-1:0] ACK_CNT_MAX = '1;

  // Per-quarter pull-low patterns, bit n = quarter n.
  localparam logic [3:0] START_SCL = 4'b1000;
  localparam logic [3:0] START_SDA = 4'b1100;
  localparam logic [3:0] BIT_SCL   = 4'b1001;
  localparam logic [3:0] STOP_SCL  = 4'b0001;
  localparam logic [3:0] STOP_SDA  = 4'b0011;

  typedef struct packed {
    logic scl_oe;
    logic sda_oe;
  } pads_t;

  function automatic logic [1:0] next_quarter(input logic [1:0] q);
    logic [1:0] n;
    case (q)
      Q0:      n = Q1;
      Q1:      n = Q2;
      Q2:      n = Q3;
      default: n = Q0;
    endcase
    return n;
  endfunction

  function automatic pads_t bus_pattern(input state_e st, input logic [1:0] q,
                                        input logic data_bit, input logic hold_sda);
    pads_t p;
    p = '0;
    case (st)
      ST_START: begin
        p.scl_oe = START_SCL[q];
        p.sda_oe = START_SDA[q];
      end
      ST_LOAD: begin
        p.scl_oe = 1'b1;
        p.sda_oe = hold_sda;
      end
      ST_BIT: begin
        p.scl_oe = BIT_SCL[q];
        p.sda_oe = ~data_bit;
      end
      ST_ACK: begin
        p.scl_oe = BIT_SCL[q];
        p.sda_oe = 1'b0;
      end
      ST_STOP: begin
        p.scl_oe = STOP_SCL[q];
        p.sda_oe = STOP_SDA[q];
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/i2cm_byte_tx_if.sv
// Command, FIFO, pad and status bundle of the i2cm byte transmitter.
// Wires only: no latency; FIFO backpressure is the empty flag.
interface i2cm_byte_tx_if
  import i2cm_byte_tx_pkg::*;
#(
  parameter int PRESC_WIDTH = 16,
  parameter int DATA_WIDTH  = 8
);
  logic                   en;
  logic                   start;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0]  fifo_data;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   sda_i;
  logic                   scl_oe;
  logic                   sda_oe;
  logic                   busy;
  logic                   done;
  logic                   nack;
  logic [ACK_CNT_W-1:0]   ack_cnt;

  modport master (
    output en, start, prescale, fifo_data, fifo_empty, sda_i,
    input  fifo_pop, scl_oe, sda_oe, busy, done, nack, ack_cnt
  );

  modport slave (
    input  en, start, prescale, fifo_data, fifo_empty, sda_i,
    output fifo_pop, scl_oe, sda_oe, busy, done, nack, ack_cnt
  );
endinterface

// File: rtl/i2cm_byte_tx_qtick.sv
// Quarter-bit timebase: latches prescale on accept, ticks every prescale+1 cycles.
// tick is combinational from the counter; clear restarts the quarter immediately.
module i2cm_byte_tx_qtick #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   clear,
  output logic                   tick
);
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    if (!en) begin
      presc_d = '0;
    end else if (load) begin
      presc_d = prescale;
    end
    cnt_d = cnt_q + PRESC_WIDTH'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/i2cm_byte_tx.sv
// Write-only I2C master: START, FIFO bytes MSB-first with ACK check, STOP on drain/NACK.
// Pad enables registered; pops one byte per LOAD cycle only while the FIFO is non-empty.
module i2cm_byte_tx
  import i2cm_byte_tx_pkg::*;
#(
  parameter int PRESC_WIDTH = 16,
  parameter int DATA_WIDTH  = 8
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  i2cm_byte_tx_if.slave bus
);
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [1:0]             q_q, q_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [BCW-1:0]         bitcnt_q, bitcnt_d;
  logic                   nack_q, nack_d;
  logic [ACK_CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic                   scl_oe_q, scl_oe_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   fifo_pop_q, fifo_pop_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic  tick;
  logic  accept;
  logic  empty_done;
  logic  in_bus;
  logic  qclear;
  pads_t pads;

  i2cm_byte_tx_qtick #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_qtick (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (bus.en),
    .load     (accept),
    .prescale (bus.prescale),
    .clear    (qclear),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    nack_d     = nack_q;
    ack_cnt_d  = ack_cnt_q;
    accept     = 1'b0;
    empty_done = 1'b0;

    if (!bus.en) begin
      state_d   = ST_IDLE;
      shift_d   = '0;
      bitcnt_d  = '0;
      nack_d    = 1'b0;
      ack_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            nack_d    = 1'b0;
            ack_cnt_d = '0;
            if (bus.fifo_empty) begin
              empty_done = 1'b1;
            end else begin
              accept  = 1'b1;
              state_d = ST_START;
            end
          end
        end
        ST_START: begin
          if (tick && q_q == Q3) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          shift_d  = bus.fifo_data;
          bitcnt_d = BIT_LAST;
          state_d  = ST_BIT;
        end
        ST_BIT: begin
          if (tick && q_q == Q3) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            // Counter parks at zero; only LOAD reloads it.
            if (bitcnt_q == '0) begin
              state_d = ST_ACK;
            end else begin
              bitcnt_d = bitcnt_q - BCW'(1);
            end
          end
        end
        ST_ACK: begin
          if (tick && q_q == Q2) begin
            if (bus.sda_i) begin
              nack_d = 1'b1;
            end else if (ack_cnt_q != ACK_CNT_MAX) begin
              ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
            end
          end
          // nack_q can only be set within this transaction by the q2 sample above.
          if (tick && q_q == Q3) begin
            state_d = (nack_q || bus.fifo_empty) ? ST_STOP : ST_LOAD;
          end
        end
        ST_STOP: begin
          if (tick && q_q == Q3) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    in_bus = (state_q == ST_START) || (state_q == ST_BIT) ||
             (state_q == ST_ACK)   || (state_q == ST_STOP);
    qclear = !bus.en || (state_d != state_q) || !in_bus;

    if (qclear) begin
      q_d = Q0;
    end else if (tick) begin
      q_d = next_quarter(q_q);
    end else begin
      q_d = q_q;
    end

    // Outputs follow the next state so the pads change on the same edge as the FSM.
    pads       = bus_pattern(state_d, q_d, shift_d[DATA_WIDTH-1], sda_oe_q);
    scl_oe_d   = pads.scl_oe;
    sda_oe_d   = pads.sda_oe;
    fifo_pop_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE) || empty_done;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      q_q        <= Q0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      nack_q     <= 1'b0;
      ack_cnt_q  <= '0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      fifo_pop_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      nack_q     <= nack_d;
      ack_cnt_q  <= ack_cnt_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
      fifo_pop_q <= fifo_pop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.scl_oe   = scl_oe_q;
  assign bus.sda_oe   = sda_oe_q;
  assign bus.fifo_pop = fifo_pop_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.nack     = nack_q;
  assign bus.ack_cnt  = ack_cnt_q;
endmodule

// File: doc/i2cm_byte_tx.md
Name: i2cm_byte_tx

Overview:
- Write-only I2C master transmit engine. It sits directly downstream of the i2cm transmit synchronous FIFO.
- On a start request it issues START and pops bytes from the FIFO one at a time. Each byte is shifted MSB-first onto SDA, then the slave ACK is sampled.
- It issues STOP when the FIFO drains or a NACK is seen.
- It drives open-drain SCL/SDA enables toward the pad ring and reports status to the i2cm register block.

Parameters:
- PRESC_WIDTH, 16, width of the quarter-period prescale value.
- DATA_WIDTH, 8, byte width; must match the FIFO DATA_WIDTH.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable. 0 is a synchronous soft reset/abort.
- start  in  1  transaction request; sampled only in IDLE.
- prescale  in  PRESC_WIDTH  quarter-bit period = prescale+1 sys_clk cycles; latched when start is accepted.
- fifo_data  in  DATA_WIDTH  FIFO head word (combinational FIFO output, valid while not empty).
- fifo_empty  in  1  FIFO empty flag.
- fifo_pop  out  1  one-cycle pop strobe.
- sda_i  in  1  synchronized SDA pad input.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- nack  out  1  sticky: last transaction ended on a NACK.
- ack_cnt  out  8  bytes ACKed in the current or last transaction; saturates at 255.

Behaviour:
- Reset (sys_rst_n=0, asynchronous), or en=0 (synchronous, priority over everything):
  - state=IDLE; all counters and the shift register cleared.
  - scl_oe=0, sda_oe=0, fifo_pop=0, busy=0, done=0, nack=0, ack_cnt=0.
  - An abort mid-transfer releases both lines immediately. No STOP is generated.
- Quarter tick:
  - A prescale counter counts 0..prescale_latched and ticks at the terminal count.
  - Every bus state is 4 quarters, q0..q3. A quarter lasts prescale+1 cycles; prescale=0 gives 1-cycle quarters.
- IDLE:
  - start=1 and fifo_empty=0: latch prescale, clear nack and ack_cnt, go to START on that edge.
  - start=1 and fifo_empty=1: no bus activity, done pulse on the next cycle, nack=0, ack_cnt=0.
- START (SCL/SDA per quarter):
  - q0, q1: both released.
  - q2: sda_oe=1, SCL released.
  - q3: sda_oe=1, scl_oe=1.
  - Then go to LOAD.
- LOAD (exactly 1 cycle):
  - fifo_pop=1; shift register <= fifo_data; bit counter=7.
  - Then go to BIT. LOAD is entered only when fifo_empty=0.
- BIT:
  - sda_oe = ~shift[7] for all four quarters.
  - scl_oe: q0=1, q1=0, q2=0, q3=1.
  - At the end of q3: shift left, decrement the bit counter. After bit 0, go to ACK.
- ACK:
  - sda_oe=0; SCL pattern as in BIT.
  - sda_i sampled on the last cycle of q2.
  - sda_i=1: set nack, go to STOP. Remaining FIFO data is not popped.
  - sda_i=0: increment ack_cnt (saturating). Then go to LOAD if fifo_empty=0, else STOP.
  - fifo_empty is evaluated at the end of q3.
- STOP (SCL/SDA per quarter):
  - q0: sda_oe=1, scl_oe=1.
  - q1: sda_oe=1, scl_oe=0.
  - q2, q3: both released.
  - Then go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Boundary cases:
  - start asserted while busy is ignored.
  - FIFO pushes during a transaction are picked up at the next ACK decision.
  - Changing prescale mid-transaction has no effect.
  - The bit counter wraps only via reload in LOAD.
- Latency with prescale=1 (2-cycle quarter, 8-cycle bus state), N bytes:
  - DONE is entered 8 + N*(1+64+8) + 8 cycles after the start-accept edge.
  - N=1 gives 89; N=2 gives 162.

Decomposition:
- i2cm_pkg holds:
  - state encoding (IDLE, START, LOAD, BIT, ACK, STOP, DONE);
  - quarter index constants Q0..Q3;
  - per-state SCL/SDA quarter patterns.
- One natural sub-module: i2cm_qtick. It is the prescale latch, counter and tick generator, with a clear input driven by en and state transitions.

Test Plan:
- Single byte: prescale=1, FIFO holds 0xA5, sda_i=0 at ACK, pulse start.
  - Exactly one fifo_pop.
  - SDA bit pattern 1,0,1,0,0,1,0,1 while SCL is released.
  - done 89 cycles after accept; ack_cnt=1, nack=0.
- Two bytes: FIFO holds 0x3C, 0xFF, all ACKed.
  - Two pops, 73 cycles apart.
  - done at 162; ack_cnt=2.
  - No STOP between the bytes (SDA does not rise while SCL is released).
- NACK: FIFO holds 0x11, 0x22; sda_i=1 at the first ACK.
  - nack=1, ack_cnt=0, only one pop, STOP generated.
  - 0x22 remains in the FIFO (fifo_empty stays 0).
- Empty start: fifo_empty=1, pulse start.
  - scl_oe and sda_oe stay 0.
  - done high on the next cycle; busy never asserts.
- Abort: drop en during BIT of byte 1.
  - Next cycle: scl_oe=0, sda_oe=0, busy=0; no done pulse.
  - Re-enable and start: a full transaction completes normally.
- Async reset mid-ACK: assert sys_rst_n=0 between clock edges.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After release: state=IDLE, prescale=0 gives a 1-cycle quarter on the next transaction.
